target_net_sequencer: RTL

Sequencer that drives one `target_net` inference end to end. It streams all three weight layers from a synchronous parameter RAM into the net's weight port, then streams the input state vector. It then collects the `NUMBER_OF_OUTPUT_NODE` Q-values and reports the greedy action index. It replaces bench-side weight-loading loops and sits between the DQN top-level control and `target_net`.

---
 rtl/target_net_sequencer.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/target_net_sequencer.sv
// Drives one target_net inference: streams three weight layers and the state vector from the
// parameter RAM, then collects the Q-values. Optional argmax logic: `TARGET_SEQ_ARGMAX_EN.
module target_net_sequencer #(
  parameter int DATA_WIDTH                    = 32,
  parameter int LAYER_WIDTH                   = 2,
  parameter int ADDR_WIDTH                    = 12,
  parameter int NUMBER_OF_INPUT_NODE          = 2,
  parameter int NUMBER_OF_HIDDEN_NODE_LAYER_1 = 32,
  parameter int NUMBER_OF_HIDDEN_NODE_LAYER_2 = 32,
  parameter int NUMBER_OF_OUTPUT_NODE         = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_start,
  input  logic                   i_data_only,
  output logic                   o_mem_en,
  output logic [LAYER_WIDTH-1:0] o_mem_sel,
  output logic [ADDR_WIDTH-1:0]  o_mem_addr,
  input  logic [DATA_WIDTH-1:0]  i_mem_data,
  output logic                   o_weight_valid,
  output logic [LAYER_WIDTH-1:0] o_weight_layer,
  output logic [DATA_WIDTH-1:0]  o_weight,
  output logic                   o_data_valid,
  output logic [DATA_WIDTH-1:0]  o_data,
  input  logic                   i_net_valid,
  input  logic [DATA_WIDTH-1:0]  i_net_data,
  output logic                   o_busy,
  output logic                   o_done,
  output logic [((NUMBER_OF_OUTPUT_NODE > 1) ? $clog2(NUMBER_OF_OUTPUT_NODE) : 1)-1:0] o_action
);

  localparam int ACT_W = (NUMBER_OF_OUTPUT_NODE > 1) ? $clog2(NUMBER_OF_OUTPUT_NODE) : 1;
  localparam int CNT_W = $clog2(NUMBER_OF_OUTPUT_NODE + 1);

  localparam int unsigned W1_N = NUMBER_OF_HIDDEN_NODE_LAYER_1 * (NUMBER_OF_INPUT_NODE + 1);
  localparam int unsigned W2_N = NUMBER_OF_HIDDEN_NODE_LAYER_2 * (NUMBER_OF_HIDDEN_NODE_LAYER_1 + 1);
  localparam int unsigned W3_N = NUMBER_OF_OUTPUT_NODE * (NUMBER_OF_HIDDEN_NODE_LAYER_2 + 1);
  localparam int unsigned D_N  = NUMBER_OF_INPUT_NODE;

  localparam logic [ADDR_WIDTH-1:0] W1_LAST  = ADDR_WIDTH'(W1_N - 1);
  localparam logic [ADDR_WIDTH-1:0] W2_LAST  = ADDR_WIDTH'(W2_N - 1);
  localparam logic [ADDR_WIDTH-1:0] W3_LAST  = ADDR_WIDTH'(W3_N - 1);
  localparam logic [ADDR_WIDTH-1:0] D_LAST   = ADDR_WIDTH'(D_N - 1);
  localparam logic [CNT_W-1:0]      OUT_LAST = CNT_W'(NUMBER_OF_OUTPUT_NODE - 1);

  localparam logic [LAYER_WIDTH-1:0] SEL_IN = LAYER_WIDTH'(0);
  localparam logic [LAYER_WIDTH-1:0] SEL_H1 = LAYER_WIDTH'(1);
  localparam logic [LAYER_WIDTH-1:0] SEL_H2 = LAYER_WIDTH'(2);
  localparam logic [LAYER_WIDTH-1:0] SEL_OU = LAYER_WIDTH'(3);

  typedef enum logic [2:0] {
    S_IDLE, S_W1, S_W2, S_W3, S_GAP, S_DATA, S_WAIT_OUT, S_FINISH
  } state_t;

  state_t                  r_state, w_state_nxt;
  state_t                  r_resume, w_resume_nxt;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [CNT_W-1:0]        r_cnt;
  logic                    w_mem_en;
  logic [LAYER_WIDTH-1:0]  w_mem_sel;
  logic                    w_net_take;

  logic                    r_v1, r_v2, r_isw1, r_isw2;
  logic [LAYER_WIDTH-1:0]  r_tag1, r_tag2;
  logic [DATA_WIDTH-1:0]   r_word;

  // Net results are only accepted once the state-vector words have fully drained.
  assign w_net_take = (r_state == S_WAIT_OUT) && i_net_valid && !r_v1 && !r_v2;

  always_comb begin
    w_state_nxt  = r_state;
    w_resume_nxt = r_resume;
    w_mem_en     = 1'b0;
    w_mem_sel    = '0;
    case (r_state)
      S_IDLE: begin
        if (i_start) w_state_nxt = i_data_only ? S_DATA : S_W1;
      end
      S_W1: begin
        w_mem_en  = 1'b1;
        w_mem_sel = SEL_H1;
        if (r_addr == W1_LAST) begin
          w_state_nxt  = S_GAP;
          w_resume_nxt = S_W2;
        end
      end
      S_W2: begin
        w_mem_en  = 1'b1;
        w_mem_sel = SEL_H2;
        if (r_addr == W2_LAST) begin
          w_state_nxt  = S_GAP;
          w_resume_nxt = S_W3;
        end
      end
      S_W3: begin
        w_mem_en  = 1'b1;
        w_mem_sel = SEL_OU;
        if (r_addr == W3_LAST) begin
          w_state_nxt  = S_GAP;
          w_resume_nxt = S_DATA;
        end
      end
      S_GAP:  w_state_nxt = r_resume;
      S_DATA: begin
        w_mem_en  = 1'b1;
        w_mem_sel = SEL_IN;
        if (r_addr == D_LAST) w_state_nxt = S_WAIT_OUT;
      end
      S_WAIT_OUT: begin
        if (w_net_take && (r_cnt == OUT_LAST)) w_state_nxt = S_FINISH;
      end
      S_FINISH: w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_resume <= S_IDLE;
      r_addr   <= '0;
      r_cnt    <= '0;
      r_v1     <= 1'b0;
      r_v2     <= 1'b0;
      r_isw1   <= 1'b0;
      r_isw2   <= 1'b0;
      r_tag1   <= '0;
      r_tag2   <= '0;
      r_word   <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_resume <= w_resume_nxt;
      r_addr   <= (w_mem_en && (w_state_nxt == r_state)) ? r_addr + ADDR_WIDTH'(1) : '0;
      if (r_state == S_IDLE)  r_cnt <= '0;
      else if (w_net_take)    r_cnt <= r_cnt + CNT_W'(1);
      r_v1     <= w_mem_en;
      r_isw1   <= w_mem_en && (r_state != S_DATA);
      r_tag1   <= w_mem_sel;
      r_v2     <= r_v1;
      r_isw2   <= r_isw1;
      r_tag2   <= r_tag1;
      r_word   <= r_v1 ? i_mem_data : '0;
    end
  end

  assign o_mem_en       = w_mem_en;
  assign o_mem_sel      = w_mem_sel;
  assign o_mem_addr     = r_addr;
  assign o_weight_valid = r_v2 && r_isw2;
  assign o_weight_layer = o_weight_valid ? r_tag2 : '0;
  assign o_weight       = o_weight_valid ? r_word : '0;
  assign o_data_valid   = r_v2 && !r_isw2;
  assign o_data         = o_data_valid ? r_word : '0;
  assign o_busy         = (r_state != S_IDLE);
  assign o_done         = (r_state == S_FINISH);

`ifdef TARGET_SEQ_ARGMAX_EN
  logic [DATA_WIDTH-1:0] w_key, r_max_key;
  logic                  w_better;
  logic [ACT_W-1:0]      w_best_idx, r_max_idx, r_action;

  // Sign-magnitude float mapped to an unsigned-ordered key (+0 ranks above -0).
  assign w_key      = i_net_data[DATA_WIDTH-1] ? ~i_net_data : {1'b1, i_net_data[DATA_WIDTH-2:0]};
  assign w_better   = (r_cnt == '0) || (w_key > r_max_key);
  assign w_best_idx = w_better ? ACT_W'(r_cnt) : r_max_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_max_key <= '0;
      r_max_idx <= '0;
      r_action  <= '0;
    end else if (w_net_take) begin
      if (w_better) begin
        r_max_key <= w_key;
        r_max_idx <= ACT_W'(r_cnt);
      end
      if (r_cnt == OUT_LAST) r_action <= w_best_idx;
    end
  end

  assign o_action = r_action;
`else
  logic w_unused_net;
  assign w_unused_net = ^i_net_data;
  assign o_action     = '0;
`endif

endmodule
